// File: rtl/key_step_pulse.sv
// key_step_pulse: turns the raw active-low angle-adjust buttons into clean
// single-cycle inc/dec step pulses (sync -> debounce -> press/hold/repeat FSM).
// Build option: define KEY_AUTO_REPEAT_EN for hold-to-repeat; without it each
// press gives exactly one pulse and the hold/repeat timers are not built.
module key_step_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 2500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_inc_n,
  input  logic       key_dec_n,
  output logic       inc,
  output logic       dec,
  output logic [1:0] key_state
);

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
`ifdef KEY_AUTO_REPEAT_EN
  localparam logic [1:0] ST_REPEAT = 2'd2;
  localparam int unsigned T_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned T_W   = $clog2(T_MAX + 1);
  localparam logic [T_W-1:0] HOLD_END   = T_W'(HOLD_CYCLES);
  localparam logic [T_W-1:0] REPEAT_END = T_W'(REPEAT_CYCLES);
`endif

  // index 0 = inc key, index 1 = dec key; raw pins are active-low
  logic [1:0] key_raw;
  logic [1:0] pressed;
  logic [1:0] pulse;
  logic       chord;
  logic       suppress;

  assign key_raw   = {key_dec_n, key_inc_n};
  assign key_state = pressed;
  assign inc       = pulse[0];
  assign dec       = pulse[1];

  // Chord lockout stays active from the moment both keys are down until both are up.
  assign suppress = chord | (&pressed);

  // Track the chord condition until both keys are released.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chord <= 1'b0;
    end else if (&pressed) begin
      chord <= 1'b1;
    end else if (pressed == 2'b00) begin
      chord <= 1'b0;
    end
  end

  for (genvar k = 0; k < 2; k++) begin : g_key
    logic            sync1;
    logic            sync2;
    logic            deb;
    logic [DB_W-1:0] db_cnt;
    logic [1:0]      state;
    logic            pulse_r;
`ifdef KEY_AUTO_REPEAT_EN
    logic [T_W-1:0]  timer;
`endif

    assign pressed[k] = deb;
    assign pulse[k]   = pulse_r;

    // Two-flop synchronizer; resets to the released level.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        sync1 <= 1'b1;
        sync2 <= 1'b1;
      end else begin
        sync1 <= key_raw[k];
        sync2 <= sync1;
      end
    end

    // Accept a new level only after it has differed for DEBOUNCE_CYCLES cycles.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        deb    <= 1'b0;
        db_cnt <= '0;
      end else if (~sync2 == deb) begin
        db_cnt <= '0;
      end else if (db_cnt >= DB_LAST) begin
        deb    <= ~sync2;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end

    // Press / hold / repeat sequencing; release or chord forces IDLE silently.
    // The timer is loaded with 1 alongside each pulse so it pulses again on
    // reaching exactly HOLD_CYCLES / REPEAT_CYCLES cycles later.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        state   <= ST_IDLE;
        pulse_r <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
        timer   <= '0;
`endif
      end else begin
        pulse_r <= 1'b0;
        if (!deb || suppress) begin
          state <= ST_IDLE;
`ifdef KEY_AUTO_REPEAT_EN
          timer <= '0;
`endif
        end else begin
          case (state)
            ST_IDLE: begin
              pulse_r <= 1'b1;
              state   <= ST_HOLD;
`ifdef KEY_AUTO_REPEAT_EN
              timer   <= T_W'(1);
`endif
            end
`ifdef KEY_AUTO_REPEAT_EN
            ST_HOLD: begin
              if (timer >= HOLD_END) begin
                pulse_r <= 1'b1;
                timer   <= T_W'(1);
                state   <= ST_REPEAT;
              end else begin
                timer <= timer + 1'b1;
              end
            end
            ST_REPEAT: begin
              if (timer >= REPEAT_END) begin
                pulse_r <= 1'b1;
                timer   <= T_W'(1);
              end else begin
                timer <= timer + 1'b1;
              end
            end
`else
            ST_HOLD: begin
              state <= ST_HOLD;
            end
`endif
            default: begin
              state <= ST_IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule
